// File: rtl/tick_pkg.sv
// Shared elaboration helpers for the game tick scheduler: per-level divisors,
// safe clog2 and the parameter range check.
package tick_pkg;

    function automatic int div_for_level(
        input int clk_freq,
        input int base,
        input int step,
        input int lvl
    );
        return clk_freq / (base + lvl * step);
    endfunction

    function automatic int clog2_safe(input int value);
        int result;
        if (value <= 32'sd1) begin
            result = 32'sd1;
        end else begin
            result = $clog2(value);
        end
        return result;
    endfunction

    // The slowest-to-fastest table must keep every period at two cycles or more.
    function automatic bit params_ok(
        input int clk_freq,
        input int base,
        input int step,
        input int num_levels,
        input int anim_div,
        input int tcnt_w
    );
        bit ok;
        ok = (num_levels >= 32'sd1) && (num_levels <= 32'sd16) &&
             (anim_div >= 32'sd1) && (tcnt_w >= 32'sd1) &&
             (base >= 32'sd1) && (step >= 32'sd0) && (clk_freq >= 32'sd1);
        if (ok) begin
            ok = div_for_level(clk_freq, base, step, num_levels - 32'sd1) >= 32'sd2;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Reloadable modulo counter: counts 0..limit while enabled and flags the
// enabled cycle on which it wraps back to 0.
module tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = W'(1'b1);

    logic [W-1:0] count_r;

    // Wrap is combinational so the parent registers it alongside its own outputs.
    always_comb begin
        if (en) begin
            wrap = (count_r == limit);
        end else begin
            wrap = 1'b0;
        end
    end

    // Phase register: holds while disabled, reloads to 0 on wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (en) begin
            if (wrap) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + ONE;
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/game_tick_sched.sv
// Game-step pulse generator with selectable speed level, pause, single step,
// a divided animation pulse and a wrapping tick counter.
module game_tick_sched
    import tick_pkg::*;
#(
    parameter int  CLK_FREQ   = 50_000_000,
    parameter int  BASE_TPS   = 10,
    parameter int  TPS_STEP   = 2,
    parameter int  NUM_LEVELS = 8,
    parameter int  ANIM_DIV   = 4,
    parameter int  TCNT_W     = 16,
    localparam int LEVEL_W    = clog2_safe(NUM_LEVELS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              step,
    input  logic              level_up,
    input  logic              level_clr,
    output logic [LEVEL_W-1:0] level,
    output logic              game_tick,
    output logic              anim_tick,
    output logic [TCNT_W-1:0] tick_count
);

    localparam int DIV0   = div_for_level(CLK_FREQ, BASE_TPS, TPS_STEP, 32'sd0);
    localparam int CNT_W  = clog2_safe(DIV0);
    localparam int ACNT_W = clog2_safe(ANIM_DIV);

    localparam logic [LEVEL_W-1:0] MAX_LEVEL  = LEVEL_W'(NUM_LEVELS - 32'sd1);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1'b1);
    localparam logic [TCNT_W-1:0]  TCNT_ONE   = TCNT_W'(1'b1);
    localparam logic [ACNT_W-1:0]  ANIM_LIMIT = ACNT_W'(ANIM_DIV - 32'sd1);

    if (!params_ok(CLK_FREQ, BASE_TPS, TPS_STEP, NUM_LEVELS, ANIM_DIV, TCNT_W)) begin : g_param_check
        $error("game_tick_sched: parameter set out of range");
    end

    // Reload values DIV(L)-1 packed per level; DIV(0) is the largest so CNT_W fits all.
    function automatic logic [NUM_LEVELS*CNT_W-1:0] build_limits();
        logic [NUM_LEVELS*CNT_W-1:0] tbl;
        tbl = '0;
        for (int l = 0; l < NUM_LEVELS; l++) begin
            tbl[l*CNT_W +: CNT_W] = CNT_W'(div_for_level(CLK_FREQ, BASE_TPS, TPS_STEP, l) - 32'sd1);
        end
        return tbl;
    endfunction

    localparam logic [NUM_LEVELS*CNT_W-1:0] LIMITS = build_limits();

    logic [LEVEL_W-1:0] level_r;
    logic [LEVEL_W-1:0] pend_level_r;
    logic [LEVEL_W-1:0] pend_next_s;
    logic [CNT_W-1:0]   limit_s;
    logic               cnt_wrap_s;
    logic               anim_wrap_s;
    logic               fire_s;
    logic               game_tick_r;
    logic               anim_tick_r;
    logic [TCNT_W-1:0]  tick_count_r;

    // Divisor for the currently applied level.
    always_comb begin
        limit_s = LIMITS[int'(level_r) * CNT_W +: CNT_W];
    end

    tick_counter #(.W(CNT_W)) u_phase (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run),
        .limit   (limit_s),
        .wrap    (cnt_wrap_s)
    );

    // Periodic wrap while running; a step only counts while paused.
    always_comb begin
        if (run) begin
            fire_s = cnt_wrap_s;
        end else begin
            fire_s = step;
        end
    end

    tick_counter #(.W(ACNT_W)) u_anim (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (fire_s),
        .limit   (ANIM_LIMIT),
        .wrap    (anim_wrap_s)
    );

    // Pending level: clear wins over up, up saturates at the top level.
    always_comb begin
        if (level_clr) begin
            pend_next_s = '0;
        end else if (level_up && (pend_level_r != MAX_LEVEL)) begin
            pend_next_s = pend_level_r + LEVEL_ONE;
        end else begin
            pend_next_s = pend_level_r;
        end
    end

    // Level state and registered outputs, all moving on the tick edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_level_r <= '0;
            level_r      <= '0;
            game_tick_r  <= 1'b0;
            anim_tick_r  <= 1'b0;
            tick_count_r <= '0;
        end else begin
            pend_level_r <= pend_next_s;
            game_tick_r  <= fire_s;
            anim_tick_r  <= anim_wrap_s;
            if (fire_s) begin
                level_r      <= pend_next_s;
                tick_count_r <= tick_count_r + TCNT_ONE;
            end else begin
                level_r      <= level_r;
                tick_count_r <= tick_count_r;
            end
        end
    end

    assign level      = level_r;
    assign game_tick  = game_tick_r;
    assign anim_tick  = anim_tick_r;
    assign tick_count = tick_count_r;

endmodule

// File: tb/tb_game_tick_sched.sv
// Directed bench for game_tick_sched with DIV = 100, 50, 33, 25 and ANIM_DIV = 3.
module tb_game_tick_sched;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic       step;
    logic       level_up;
    logic       level_clr;
    logic [1:0] level;
    logic       game_tick;
    logic       anim_tick;
    logic [3:0] tick_count;

    int checks;
    int errors;
    int total_ticks;

    game_tick_sched #(
        .CLK_FREQ   (1000),
        .BASE_TPS   (10),
        .TPS_STEP   (10),
        .NUM_LEVELS (4),
        .ANIM_DIV   (3),
        .TCNT_W     (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .step       (step),
        .level_up   (level_up),
        .level_clr  (level_clr),
        .level      (level),
        .game_tick  (game_tick),
        .anim_tick  (anim_tick),
        .tick_count (tick_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles (negedges) until game_tick is seen high; -1 if the budget expires.
    task automatic wait_tick(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (game_tick === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        run = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (game_tick !== 1'b0) begin errors++; $display("FAIL rst_game_tick: got %b want 0", game_tick); end
        checks++; if (anim_tick !== 1'b0) begin errors++; $display("FAIL rst_anim_tick: got %b want 0", anim_tick); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
        checks++; if (tick_count !== 4'd0) begin errors++; $display("FAIL rst_tick_count: got %0d want 0", tick_count); end
        reset_n = 1'b1;
        wait_tick(150, n);
        checks++; if (n != 100) begin errors++; $display("FAIL first_tick: got cycle %0d want 100", n); end
        checks++; if (tick_count !== 4'd1) begin errors++; $display("FAIL count_1: got %0d want 1", tick_count); end
        checks++; if (anim_tick !== 1'b0) begin errors++; $display("FAIL anim_tick1: got %b want 0", anim_tick); end
        @(negedge clk);
        checks++; if (game_tick !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b want 0", game_tick); end
        wait_tick(150, n);
        checks++; if (n != 99) begin errors++; $display("FAIL period_2: got %0d want 99", n); end
        checks++; if (tick_count !== 4'd2) begin errors++; $display("FAIL count_2: got %0d want 2", tick_count); end
        wait_tick(150, n);
        checks++; if (n != 100) begin errors++; $display("FAIL period_3: got %0d want 100", n); end
        checks++; if (tick_count !== 4'd3) begin errors++; $display("FAIL count_3: got %0d want 3", tick_count); end
        checks++; if (anim_tick !== 1'b1) begin errors++; $display("FAIL anim_tick3: got %b want 1", anim_tick); end
        total_ticks = 3;
    endtask

    task automatic test_level_ramp();
        int n;
        repeat (30) @(negedge clk);
        level_up = 1'b1;
        repeat (5) @(negedge clk);
        level_up = 1'b0;
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL level_held: got %0d want 0", level); end
        wait_tick(150, n);
        checks++; if (n != 65) begin errors++; $display("FAIL ramp_tick: got %0d want 65", n); end
        checks++; if (level !== 2'd3) begin errors++; $display("FAIL level_sat: got %0d want 3", level); end
        wait_tick(150, n);
        checks++; if (n != 25) begin errors++; $display("FAIL period_l3: got %0d want 25", n); end
        level_up = 1'b1;
        @(negedge clk);
        level_up = 1'b0;
        wait_tick(150, n);
        checks++; if (n != 24) begin errors++; $display("FAIL period_l3b: got %0d want 24", n); end
        checks++; if (level !== 2'd3) begin errors++; $display("FAIL level_stays3: got %0d want 3", level); end
        total_ticks += 3;
    endtask

    task automatic test_simultaneous();
        int n;
        level_clr = 1'b1;
        @(negedge clk);
        level_clr = 1'b0;
        level_up = 1'b1;
        repeat (2) @(negedge clk);
        level_up = 1'b0;
        wait_tick(150, n);
        checks++; if (n != 22) begin errors++; $display("FAIL to_l2_tick: got %0d want 22", n); end
        checks++; if (level !== 2'd2) begin errors++; $display("FAIL level_2: got %0d want 2", level); end
        wait_tick(150, n);
        checks++; if (n != 33) begin errors++; $display("FAIL period_l2: got %0d want 33", n); end
        level_up = 1'b1;
        level_clr = 1'b1;
        @(negedge clk);
        level_up = 1'b0;
        level_clr = 1'b0;
        wait_tick(150, n);
        checks++; if (n != 32) begin errors++; $display("FAIL clr_tick: got %0d want 32", n); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL clr_wins: got %0d want 0", level); end
        wait_tick(150, n);
        checks++; if (n != 100) begin errors++; $display("FAIL period_back: got %0d want 100", n); end
        total_ticks += 4;
    endtask

    task automatic test_pause_step();
        int n;
        int seen;
        repeat (40) @(negedge clk);
        run = 1'b0;
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (game_tick === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL paused_ticks: got %0d want 0", seen); end
        checks++; if (tick_count !== 4'd10) begin errors++; $display("FAIL paused_count: got %0d want 10", tick_count); end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        checks++; if (game_tick !== 1'b1) begin errors++; $display("FAIL step_tick: got %b want 1", game_tick); end
        checks++; if (tick_count !== 4'd11) begin errors++; $display("FAIL step_count: got %0d want 11", tick_count); end
        checks++; if (anim_tick !== 1'b0) begin errors++; $display("FAIL step_anim: got %b want 0", anim_tick); end
        @(negedge clk);
        checks++; if (game_tick !== 1'b0) begin errors++; $display("FAIL step_width: got %b want 0", game_tick); end
        run = 1'b1;
        // cnt resumes at 40: 59 increments up to 99, then the wrap edge.
        wait_tick(150, n);
        checks++; if (n != 60) begin errors++; $display("FAIL resume_tick: got %0d want 60", n); end
        checks++; if (tick_count !== 4'd12) begin errors++; $display("FAIL resume_count: got %0d want 12", tick_count); end
        checks++; if (anim_tick !== 1'b1) begin errors++; $display("FAIL resume_anim: got %b want 1", anim_tick); end
        total_ticks += 2;
    endtask

    task automatic test_anim_wrap();
        int n;
        int anims;
        int wraps;
        logic [3:0] exp_count;
        logic exp_anim;
        anims = 0;
        wraps = 0;
        exp_count = 4'd12;
        for (int k = 0; k < 48; k++) begin
            wait_tick(150, n);
            total_ticks++;
            exp_count = exp_count + 4'd1;
            exp_anim = ((total_ticks % 3) == 0);
            if (anim_tick === 1'b1) anims++;
            if (tick_count === 4'd0) wraps++;
            checks++; if (n != 100) begin errors++; $display("FAIL anim_period[%0d]: got %0d want 100", k, n); end
            checks++; if (tick_count !== exp_count) begin errors++; $display("FAIL anim_count[%0d]: got %0d want %0d", k, tick_count, exp_count); end
            checks++; if (anim_tick !== exp_anim) begin errors++; $display("FAIL anim_flag[%0d]: got %b want %b", k, anim_tick, exp_anim); end
        end
        checks++; if (anims != 16) begin errors++; $display("FAIL anim_total: got %0d want 16", anims); end
        // 48 consecutive 4-bit values contain exactly three zeros.
        checks++; if (wraps != 3) begin errors++; $display("FAIL wrap_total: got %0d want 3", wraps); end
    endtask

    task automatic test_reset_mid();
        int n;
        level_up = 1'b1;
        repeat (2) @(negedge clk);
        level_up = 1'b0;
        wait_tick(150, n);
        checks++; if (n != 98) begin errors++; $display("FAIL pre_rst_tick: got %0d want 98", n); end
        checks++; if (level !== 2'd2) begin errors++; $display("FAIL pre_rst_level: got %0d want 2", level); end
        checks++; if (tick_count !== 4'd13) begin errors++; $display("FAIL pre_rst_count: got %0d want 13", tick_count); end
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL async_level: got %0d want 0", level); end
        checks++; if (tick_count !== 4'd0) begin errors++; $display("FAIL async_count: got %0d want 0", tick_count); end
        checks++; if (game_tick !== 1'b0 || anim_tick !== 1'b0) begin errors++; $display("FAIL async_pulses: got %b%b want 00", game_tick, anim_tick); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_tick(150, n);
        checks++; if (n != 100) begin errors++; $display("FAIL post_rst_tick: got %0d want 100", n); end
        checks++; if (tick_count !== 4'd1 || level !== 2'd0) begin errors++; $display("FAIL post_rst_state: got count %0d level %0d want 1 0", tick_count, level); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        total_ticks = 0;
        reset_n = 1'b0;
        run = 1'b0;
        step = 1'b0;
        level_up = 1'b0;
        level_clr = 1'b0;
        test_reset();
        test_level_ramp();
        test_simultaneous();
        test_pause_step();
        test_anim_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
